// File: rtl/coo_edge_loader.sv
// coo_edge_loader: buffers one graph's COO edge list, pulses start to the GCN core,
// then serves its column lookups until the core reports done.
module coo_edge_loader #(
  parameter int COO_NUM_OF_COLS = 6,
  parameter int NUM_OF_NODES    = 6,
  parameter int COO_BW          = $clog2(COO_NUM_OF_COLS),
  parameter int CNT_BW          = $clog2(COO_NUM_OF_COLS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [COO_BW-1:0] load_src,
  input  logic [COO_BW-1:0] load_dst,
  input  logic              load_last,
  input  logic [COO_BW-1:0] coo_address,
  output logic [COO_BW-1:0] coo_in [0:1],
  output logic              start,
  input  logic              gcn_done,
  output logic              busy,
  output logic [CNT_BW-1:0] edge_count,
  output logic              range_err,
  output logic              short_frame
);
  localparam logic [CNT_BW-1:0] COLS  = CNT_BW'(COO_NUM_OF_COLS);
  localparam logic [COO_BW:0]   NODES = (COO_BW + 1)'(NUM_OF_NODES);
  typedef enum logic [1:0] {LOAD, START, RUN} state_t;
  state_t            state_q;
  logic [COO_BW-1:0] src_q [COO_NUM_OF_COLS];
  logic [COO_BW-1:0] dst_q [COO_NUM_OF_COLS];
  logic [CNT_BW-1:0] edge_count_q, edge_count_d;
  logic              load_ready_q, start_q, busy_q, range_err_q, short_frame_q;
  logic              accept, in_range, frame_end;
  assign accept       = load_valid && load_ready_q && state_q == LOAD;
  assign in_range     = ({1'b0, load_src} < NODES) && ({1'b0, load_dst} < NODES);
  assign edge_count_d = edge_count_q + CNT_BW'(in_range);
  // An out-of-range last edge still closes the frame.
  assign frame_end    = load_last || edge_count_d == COLS;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= LOAD;
      edge_count_q  <= '0;
      load_ready_q  <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      range_err_q   <= 1'b0;
      short_frame_q <= 1'b0;
      for (int i = 0; i < COO_NUM_OF_COLS; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          load_ready_q <= !(accept && frame_end);
          if (accept) begin
            if (in_range) begin
              edge_count_q <= edge_count_d;
              for (int i = 0; i < COO_NUM_OF_COLS; i++)
                if (edge_count_q == CNT_BW'(i)) begin
                  src_q[i] <= load_src;
                  dst_q[i] <= load_dst;
                end
            end else begin
              range_err_q <= 1'b1;
            end
            if (load_last && edge_count_d != COLS) short_frame_q <= 1'b1;
            if (frame_end) begin
              state_q <= START;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        START: begin
          state_q <= RUN;
          start_q <= 1'b0;
        end
        RUN: begin
          if (gcn_done) begin
            state_q      <= LOAD;
            edge_count_q <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            for (int i = 0; i < COO_NUM_OF_COLS; i++) begin
              src_q[i] <= '0;
              dst_q[i] <= '0;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end
  // Addresses past the table read as an empty column.
  always_comb begin
    coo_in[0] = '0;
    coo_in[1] = '0;
    for (int i = 0; i < COO_NUM_OF_COLS; i++)
      if (coo_address == COO_BW'(i)) begin
        coo_in[0] = src_q[i];
        coo_in[1] = dst_q[i];
      end
  end
  assign load_ready  = load_ready_q;
  assign start       = start_q;
  assign busy        = busy_q;
  assign edge_count  = edge_count_q;
  assign range_err   = range_err_q;
  assign short_frame = short_frame_q;
endmodule
